mac_engine: RTL

Inference datapath that sits downstream of avalon_interface. On start_calc it streams the 784-pixel image buffer and the weight buffer through a two-lane multiply-accumulate pipeline. It produces 10 signed 17-bit neuron results in a result register file. The host reads these results back through output_address / result_output and polls done_calc / overflow via the status register.

---
 rtl/mac_engine.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mac_engine.sv
// rtl/mac_engine.sv - two-lane pixel x weight MAC engine producing saturated neuron results
// Optional feature: define MAC_RELU_EN to store negative saturated results as zero.
module mac_engine #(
    parameter int NUM_OUTPUTS      = 10,
    parameter int WORDS_PER_OUTPUT = 392,
    parameter int RESULT_W         = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_calc,
    input  logic                clear_data,
    output logic [9:0]          pixel_raddr,
    input  logic [31:0]         pixel_rdata,
    output logic [11:0]         weight_raddr,
    input  logic [31:0]         weight_rdata,
    input  logic [3:0]          output_address,
    output logic [RESULT_W-1:0] result_output,
    output logic                done_calc,
    output logic                overflow,
    output logic                busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [8:0] K_LAST = 9'(WORDS_PER_OUTPUT - 1);
    localparam logic [3:0] N_LAST = 4'(NUM_OUTPUTS - 1);

    localparam logic signed [31:0] RES_MAX = (32'sd1 <<< (RESULT_W - 1)) - 32'sd1;
    localparam logic signed [31:0] RES_MIN = -(32'sd1 <<< (RESULT_W - 1));

    logic [1:0]  state_q, state_d;
    logic [3:0]  n_q, n_d;
    logic [8:0]  k_q, k_d;
    logic [8:0]  k_next;
    logic [9:0]  pixel_raddr_q, pixel_raddr_d;
    logic [11:0] weight_raddr_q, weight_raddr_d;
    logic        s2_valid_q, s2_valid_d;
    logic [3:0]  s2_n_q, s2_n_d;
    logic [8:0]  s2_k_q, s2_k_d;
    logic signed [31:0] acc_q, acc_d;
    logic [RESULT_W-1:0] result_q [NUM_OUTPUTS];
    logic [RESULT_W-1:0] result_d [NUM_OUTPUTS];
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;

    logic [7:0]          pix_a, pix_b;
    logic signed [24:0]  pa_ext, pb_ext, wa_ext, wb_ext;
    logic signed [24:0]  prod_a, prod_b;
    logic signed [25:0]  sum;
    logic signed [31:0]  base;
    logic signed [32:0]  acc_wide;
    logic signed [31:0]  acc_sat;
    logic [RESULT_W-1:0] res_val;
    logic [RESULT_W-1:0] res_store;
    logic                res_clamped;

    // Data on pixel_rdata/weight_rdata belongs to the element held in stage 2.
    always_comb begin
        pix_a  = s2_k_q[0] ? pixel_rdata[23:16] : pixel_rdata[7:0];
        pix_b  = s2_k_q[0] ? pixel_rdata[31:24] : pixel_rdata[15:8];
        pa_ext = {17'b0, pix_a};
        pb_ext = {17'b0, pix_b};
        wa_ext = {{9{weight_rdata[15]}}, weight_rdata[15:0]};
        wb_ext = {{9{weight_rdata[31]}}, weight_rdata[31:16]};
        prod_a = pa_ext * wa_ext;
        prod_b = pb_ext * wb_ext;
        sum    = {prod_a[24], prod_a} + {prod_b[24], prod_b};
        base   = (s2_k_q == 9'd0) ? 32'sd0 : acc_q;
        acc_wide = {base[31], base} + {{7{sum[25]}}, sum};
        // The accumulator saturates so very large runs keep their sign for the final clamp.
        if (acc_wide[32] != acc_wide[31]) begin
            acc_sat = acc_wide[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end else begin
            acc_sat = acc_wide[31:0];
        end
        res_clamped = 1'b0;
        if (acc_sat > RES_MAX) begin
            res_val     = RES_MAX[RESULT_W-1:0];
            res_clamped = 1'b1;
        end else if (acc_sat < RES_MIN) begin
            res_val     = RES_MIN[RESULT_W-1:0];
            res_clamped = 1'b1;
        end else begin
            res_val = acc_sat[RESULT_W-1:0];
        end
`ifdef MAC_RELU_EN
        res_store = res_val[RESULT_W-1] ? '0 : res_val;
`else
        res_store = res_val;
`endif
    end

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        k_d            = k_q;
        k_next         = '0;
        pixel_raddr_d  = pixel_raddr_q;
        weight_raddr_d = weight_raddr_q;
        s2_valid_d     = 1'b0;
        s2_n_d         = s2_n_q;
        s2_k_d         = s2_k_q;
        acc_d          = acc_q;
        result_d       = result_q;
        done_d         = done_q;
        overflow_d     = overflow_q;

        if (s2_valid_q) begin
            acc_d = acc_sat;
            if (s2_k_q == K_LAST) begin
                for (int i = 0; i < NUM_OUTPUTS; i++) begin
                    if (s2_n_q == 4'(i)) begin
                        result_d[i] = res_store;
                    end
                end
                if (res_clamped) begin
                    overflow_d = 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_calc) begin
                    state_d        = S_RUN;
                    n_d            = '0;
                    k_d            = '0;
                    pixel_raddr_d  = '0;
                    weight_raddr_d = '0;
                    overflow_d     = 1'b0;
                    done_d         = 1'b0;
                end
            end
            S_RUN: begin
                // The address pair on the bus is always the element (n_q, k_q).
                s2_valid_d = 1'b1;
                s2_n_d     = n_q;
                s2_k_d     = k_q;
                if ((k_q == K_LAST) && (n_q == N_LAST)) begin
                    state_d = S_DRAIN;
                end else begin
                    if (k_q == K_LAST) begin
                        k_next = '0;
                        n_d    = n_q + 4'd1;
                    end else begin
                        k_next = k_q + 9'd1;
                    end
                    k_d            = k_next;
                    pixel_raddr_d  = {2'b00, k_next[8:1]};
                    weight_raddr_d = weight_raddr_q + 12'd1;
                end
            end
            S_DRAIN: begin
                if (s2_valid_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_data) begin
            state_d    = S_IDLE;
            s2_valid_d = 1'b0;
            done_d     = 1'b0;
            overflow_d = 1'b0;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                result_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            n_q            <= '0;
            k_q            <= '0;
            pixel_raddr_q  <= '0;
            weight_raddr_q <= '0;
            s2_valid_q     <= 1'b0;
            s2_n_q         <= '0;
            s2_k_q         <= '0;
            acc_q          <= '0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            k_q            <= k_d;
            pixel_raddr_q  <= pixel_raddr_d;
            weight_raddr_q <= weight_raddr_d;
            s2_valid_q     <= s2_valid_d;
            s2_n_q         <= s2_n_d;
            s2_k_q         <= s2_k_d;
            acc_q          <= acc_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                result_q[i] <= result_d[i];
            end
        end
    end

    always_comb begin
        result_output = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (output_address == 4'(i)) begin
                result_output = result_q[i];
            end
        end
    end

    assign pixel_raddr  = pixel_raddr_q;
    assign weight_raddr = weight_raddr_q;
    assign done_calc    = done_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);

endmodule
